// File: rtl/v810_bus_responder.sv
// v810_bus_responder: multi-region V810 external-bus slave with per-region wait states and bus width.
// Build macro BUSRSP_IO_EN: when defined, I/O cycles are served by region IO_RGN instead of locally.
module v810_bus_responder #(
   parameter int RGN_BITS = 1,
   parameter int WS_W     = 4,
   parameter int MA_W     = 12,
   parameter int IO_RGN   = 0
) (
   input  logic                           CLK,
   input  logic                           RESn,
   input  logic                           CE,
   input  logic [31:0]                    A,
   input  logic [3:0]                     BEn,
   input  logic [1:0]                     ST,
   input  logic                           DAn,
   input  logic                           MRQn,
   input  logic                           RW,
   input  logic [31:0]                    D_I,
   output logic [31:0]                    D_O,
   output logic                           READYn,
   output logic                           SZRQn,
   input  logic [(2**RGN_BITS)*WS_W-1:0]  CFG_WS,
   input  logic [(2**RGN_BITS)-1:0]       CFG_DW16,
   output logic [(2**RGN_BITS)-1:0]       MEM_SELn,
   output logic [MA_W-1:0]                MEM_A,
   output logic [3:0]                     MEM_BEn,
   output logic                           MEM_WEn,
   output logic [31:0]                    MEM_DI,
   input  logic [(2**RGN_BITS)*32-1:0]    MEM_DO
);

   localparam int NRGN = 2**RGN_BITS;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDY} state_t;

   state_t                state_q, state_d;
   logic [WS_W-1:0]       cnt_q, cnt_d;
   logic [RGN_BITS-1:0]   rgn_q, rgn_d;
   logic [MA_W-1:0]       a_q, a_d;
   logic [3:0]            ben_q, ben_d;
   logic                  rw_q, rw_d;
   logic                  dw16_q, dw16_d;
   logic                  mem_q, mem_d;

   logic                  ready_n_q, ready_n_d;
   logic                  szrq_n_q, szrq_n_d;
   logic                  we_n_q, we_n_d;
   logic [NRGN-1:0]       sel_n_q, sel_n_d;
   logic [31:0]           d_o_q, d_o_d;

   logic [RGN_BITS-1:0]   dec_rgn;
   logic                  dec_mem;
   logic [WS_W-1:0]       dec_ws;
   logic                  dec_dw16;
   logic [31:0]           rd_word;
   logic                  unused_sig;

   function automatic logic [31:0] lane_rd(input logic [31:0] w, input logic dw16, input logic a1);
      if (!dw16) return w;
      return a1 ? {w[31:16], w[31:16]} : {w[15:0], w[15:0]};
   endfunction

   function automatic logic [3:0] lane_be(input logic [3:0] be, input logic dw16, input logic a1);
      if (!dw16) return be;
      return a1 ? (be | 4'b0011) : (be | 4'b1100);
   endfunction

`ifdef BUSRSP_IO_EN
   assign dec_rgn    = MRQn ? RGN_BITS'(IO_RGN) : A[31 -: RGN_BITS];
   assign dec_mem    = 1'b1;
   assign unused_sig = ^{ST, A};
`else
   // I/O cycles are answered here with no memory access
   assign dec_rgn    = A[31 -: RGN_BITS];
   assign dec_mem    = ~MRQn;
   assign unused_sig = ^{ST, A, (IO_RGN < NRGN)};
`endif

   always_comb begin
      dec_ws   = '0;
      dec_dw16 = 1'b0;
      for (int r = 0; r < NRGN; r++) begin
         if (dec_rgn == RGN_BITS'(r)) begin
            dec_ws   = CFG_WS[r*WS_W +: WS_W];
            dec_dw16 = CFG_DW16[r];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rgn_d   = rgn_q;
      a_d     = a_q;
      ben_d   = ben_q;
      rw_d    = rw_q;
      dw16_d  = dw16_q;
      mem_d   = mem_q;
      case (state_q)
         S_IDLE: begin
            if (!DAn) begin
               rgn_d   = dec_rgn;
               a_d     = A[MA_W-1:0];
               ben_d   = BEn;
               rw_d    = RW;
               mem_d   = dec_mem;
               dw16_d  = dec_mem & dec_dw16;
               cnt_d   = dec_mem ? dec_ws : '0;
               state_d = (cnt_d == '0) ? S_RDY : S_WAIT;
            end
         end
         S_WAIT: begin
            // Abort wins over completion, so a dropped strobe never produces READYn
            if (DAn) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == WS_W'(1)) begin
               state_d = S_RDY;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - WS_W'(1);
            end
         end
         S_RDY:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_word = '0;
      for (int r = 0; r < NRGN; r++) begin
         if (rgn_d == RGN_BITS'(r)) rd_word = MEM_DO[r*32 +: 32];
      end
   end

   always_comb begin
      ready_n_d = (state_d != S_RDY);
      szrq_n_d  = !((state_d == S_RDY) && dw16_d);
      we_n_d    = !((state_d == S_RDY) && !rw_d && mem_d);
      d_o_d     = ((state_d == S_RDY) && rw_d && mem_d) ? lane_rd(rd_word, dw16_d, a_d[1]) : '0;
      sel_n_d   = '1;
      if ((state_d != S_IDLE) && mem_d) begin
         for (int r = 0; r < NRGN; r++) begin
            if (rgn_d == RGN_BITS'(r)) sel_n_d[r] = 1'b0;
         end
      end
   end

   // Control and bus strobes: reset asynchronously so a mid-cycle reset drops them at once
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ready_n_q <= 1'b1;
         szrq_n_q  <= 1'b1;
         we_n_q    <= 1'b1;
         sel_n_q   <= '1;
         d_o_q     <= '0;
      end else if (CE) begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ready_n_q <= ready_n_d;
         szrq_n_q  <= szrq_n_d;
         we_n_q    <= we_n_d;
         sel_n_q   <= sel_n_d;
         d_o_q     <= d_o_d;
      end
   end

   // Latched cycle attributes: only meaningful while a strobe is active
   always_ff @(posedge CLK) begin
      if (CE) begin
         rgn_q  <= rgn_d;
         a_q    <= a_d;
         ben_q  <= ben_d;
         rw_q   <= rw_d;
         dw16_q <= dw16_d;
         mem_q  <= mem_d;
      end
   end

   assign D_O      = d_o_q;
   assign READYn   = ready_n_q;
   assign SZRQn    = szrq_n_q;
   assign MEM_SELn = sel_n_q;
   assign MEM_WEn  = we_n_q;
   assign MEM_A    = a_q;
   assign MEM_BEn  = lane_be(ben_q, dw16_q, a_q[1]);
   assign MEM_DI   = D_I;

endmodule
